// File: rtl/neuron_preact.sv
// Pre-activation stage: accumulates Q3.4 a*w products plus bias in Q.8, then emits
// a Q3.4 result clamped to +/-SAT_MAG for the downstream sigmoid approximation.
module neuron_preact #(
  parameter int ACC_W   = 20,
  parameter int SAT_MAG = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_w,
  input  logic [7:0] in_bias,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_x,
  output logic       out_ovf
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_HI  = ACC_W'(SAT_MAG);
  localparam logic signed [ACC_W-1:0] SAT_LO  = -SAT_HI;
  localparam logic signed [7:0]       X_HI    = 8'(SAT_MAG);
  localparam logic signed [7:0]       X_LO    = -X_HI;

  state_t state, state_nxt;

  logic signed [ACC_W-1:0] acc;
  logic                    first;
  logic                    ovf_acc;

  logic                    accept;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] acc_nxt;
  logic                    clamp_evt;
  logic signed [ACC_W-1:0] t;
  logic signed [7:0]       x_nxt;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:  if (accept && in_last) state_nxt = HOLD;
      HOLD: if (out_ready)         state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == HOLD);
  end

  // One guard bit on the sum is enough: |product| and |bias<<4| are far below 2^(ACC_W-1).
  always_comb begin
    prod      = 16'(signed'(in_a)) * 16'(signed'(in_w));
    base      = first ? (ACC_W'(signed'(in_bias)) <<< 4) : acc;
    sum       = (ACC_W+1)'(base) + (ACC_W+1)'(prod);
    clamp_evt = 1'b0;
    acc_nxt   = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      clamp_evt = 1'b1;
      acc_nxt   = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    t = acc_nxt >>> 4;
    if (t > SAT_HI)      x_nxt = X_HI;
    else if (t < SAT_LO) x_nxt = X_LO;
    else                 x_nxt = t[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      first   <= 1'b1;
      ovf_acc <= 1'b0;
      out_x   <= '0;
      out_ovf <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        out_x   <= x_nxt;
        out_ovf <= ovf_acc | clamp_evt;
        acc     <= '0;
        ovf_acc <= 1'b0;
        first   <= 1'b1;
      end else begin
        acc     <= acc_nxt;
        ovf_acc <= ovf_acc | clamp_evt;
        first   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neuron_preact.sv
// Directed bench for neuron_preact: hand-computed Q3.4 results, backpressure,
// accumulator saturation and mid-vector reset.
module tb_neuron_preact;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_w, in_bias;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_x;
  logic       out_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  neuron_preact #(.ACC_W(20), .SAT_MAG(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_w     (in_w),
    .in_bias  (in_bias),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x    (out_x),
    .out_ovf  (out_ovf)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and holds it until accepted (bounded wait).
  task automatic beat(input int a, input int w, input int b, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_a     = 8'(a);
    in_w     = 8'(w);
    in_bias  = 8'(b);
    in_last  = last;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("beat_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Checks the result the cycle after the last beat, then drains it.
  task automatic result(input string tag, input int x, input int ovf);
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_x"}, int'($signed(out_x)), x);
    check({tag, "_ovf"}, int'(out_ovf), ovf);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain"}, int'(out_valid), 0);
    check({tag, "_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_w = '0; in_bias = '0; in_last = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_x", int'(out_x), 0);
    check("rst_out_ovf", int'(out_ovf), 0);
    check("rst_in_ready", int'(in_ready), 1);

    beat(16, 16, 0, 1'b1);    result("basic", 16, 0);
    beat(16, 8, -8, 1'b1);    result("bias_neg", 0, 0);
    beat(0, 0, 4, 1'b1);      result("bias_pos", 4, 0);
    beat(1, 1, 0, 1'b1);      result("floor_pos", 0, 0);
    beat(-1, 1, 0, 1'b1);     result("floor_neg", -1, 0);
    beat(32, 32, 0, 1'b0);
    beat(32, 32, 0, 1'b1);    result("clamp_hi", 64, 0);
    beat(-32, 32, 0, 1'b0);
    beat(-32, 32, 0, 1'b1);   result("clamp_lo", -64, 0);

    // Backpressure: result held, pending beat not consumed while in HOLD.
    beat(16, 16, 0, 1'b1);
    in_valid = 1'b1; in_a = 8'd16; in_w = 8'd16; in_bias = 8'd5; in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_valid", int'(out_valid), 1);
      check("bp_x", int'($signed(out_x)), 16);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_released", int'(out_valid), 0);
    // Held beat now accepted as first beat: 5*16 + 256 = 336 -> 21.
    beat(16, 16, 5, 1'b0);
    beat(0, 0, 0, 1'b1);      result("bp_next", 21, 0);

    // 40 * 16384 overflows a 20-bit accumulator; pinned at 524287 -> 32767 -> 64.
    for (int i = 0; i < 40; i++) beat(-128, -128, 0, 1'b0);
    beat(0, 0, 0, 1'b1);      result("sat", 64, 1);
    beat(16, 16, 0, 1'b1);    result("post_sat", 16, 0);

    for (int i = 0; i < 3; i++) beat(32, 32, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", int'(in_ready), 1);
    beat(16, 16, 0, 1'b1);    result("midrst", 16, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
